// File: rtl/mont_exp_ctrl.sv
// Montgomery-domain modular exponentiation sequencer.
// Left-to-right square-and-multiply over a latched exponent. All arithmetic is
// delegated to an external Montgomery multiplier through a start/done
// handshake that tolerates a multiplier holding done high.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; result holds the last value
// SCAN     | walking exponent bits MSB first, skipping leading zeros
// SQR_REQ  | present acc*acc to the multiplier, raise mm_start
// SQR_WAIT | hold mm_start and operands until mm_done
// SQR_REL  | wait for the multiplier to drop mm_done
// MUL_REQ  | present acc*base to the multiplier, raise mm_start
// MUL_WAIT | hold mm_start and operands until mm_done
// MUL_REL  | wait for the multiplier to drop mm_done
// FIN      | publish result, pulse done, clear busy
module mont_exp_ctrl #(
    parameter int WIDTH = 256,
    parameter int EXP_W = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base_m,
    input  logic [WIDTH-1:0] one_m,
    input  logic [EXP_W-1:0] exp,
    input  logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_p,
    input  logic [WIDTH-1:0] mm_m,
    input  logic             mm_done
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [3:0] {
        IDLE,
        SCAN,
        SQR_REQ,
        SQR_WAIT,
        SQR_REL,
        MUL_REQ,
        MUL_WAIT,
        MUL_REL,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   base_q, base_d;
    logic [WIDTH-1:0]   one_q, one_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mm_start_q, mm_start_d;
    logic [WIDTH-1:0]   mm_a_q, mm_a_d;
    logic [WIDTH-1:0]   mm_b_q, mm_b_d;
    logic [WIDTH-1:0]   mm_p_q, mm_p_d;

    logic               last_bit;
    logic               cur_bit;

    assign last_bit = (idx_q == '0);
    assign cur_bit  = exp_q[idx_q];

    // State and datapath registers; reset forces the handshake low immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            base_q     <= '0;
            one_q      <= '0;
            exp_q      <= '0;
            p_q        <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_p_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            base_q     <= base_d;
            one_q      <= one_d;
            exp_q      <= exp_d;
            p_q        <= p_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mm_start_q <= mm_start_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            mm_p_q     <= mm_p_d;
        end
    end

    // Next-state and register updates for the square-and-multiply walk.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        base_d     = base_q;
        one_d      = one_q;
        exp_d      = exp_q;
        p_d        = p_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mm_start_d = mm_start_q;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        mm_p_d     = mm_p_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_m;
                    one_d   = one_m;
                    exp_d   = exp;
                    p_d     = P;
                    idx_d   = IDX_W'(EXP_W - 1);
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cur_bit) begin
                    acc_d = base_q;
                    if (last_bit) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = SQR_REQ;
                    end
                end else if (last_bit) begin
                    // Exponent was zero: x^0 is Montgomery one.
                    acc_d   = one_q;
                    state_d = FIN;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            SQR_REQ: begin
                // Never raise mm_start into a still-asserted mm_done.
                if (!mm_done) begin
                    mm_a_d     = acc_q;
                    mm_b_d     = acc_q;
                    mm_p_d     = p_q;
                    mm_start_d = 1'b1;
                    state_d    = SQR_WAIT;
                end
            end
            SQR_WAIT: begin
                if (mm_done) begin
                    acc_d      = mm_m;
                    mm_start_d = 1'b0;
                    state_d    = SQR_REL;
                end
            end
            SQR_REL: begin
                if (!mm_done) begin
                    if (cur_bit) begin
                        state_d = MUL_REQ;
                    end else if (last_bit) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = SQR_REQ;
                    end
                end
            end
            MUL_REQ: begin
                if (!mm_done) begin
                    mm_a_d     = acc_q;
                    mm_b_d     = base_q;
                    mm_p_d     = p_q;
                    mm_start_d = 1'b1;
                    state_d    = MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                if (mm_done) begin
                    acc_d      = mm_m;
                    mm_start_d = 1'b0;
                    state_d    = MUL_REL;
                end
            end
            MUL_REL: begin
                if (!mm_done) begin
                    if (last_bit) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = SQR_REQ;
                    end
                end
            end
            FIN: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result   = result_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign mm_start = mm_start_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_p     = mm_p_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier with random
// latency, scoreboard of expected plain-form results and multiply counts.
module tb_mont_exp_ctrl;

    localparam int WIDTH = 256;
    localparam int EXP_W = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] base_m, one_m, P;
    logic [EXP_W-1:0] exp;
    logic [WIDTH-1:0] result;
    logic             busy, done, mm_start, mm_done;
    logic [WIDTH-1:0] mm_a, mm_b, mm_p, mm_m;

    int checks = 0;
    int errors = 0;

    mont_exp_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base_m(base_m), .one_m(one_m), .exp(exp), .P(P),
        .result(result), .busy(busy), .done(done),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_p(mm_p),
        .mm_m(mm_m), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    // ---------------- arithmetic helpers (small moduli only) ----------------
    function automatic longint r_mod(input longint p);
        longint r = 1;
        for (int i = 0; i < WIDTH; i++) r = (r * 2) % p;
        return r;
    endfunction

    function automatic longint inv_mod(input longint a, input longint p);
        longint t = 0, nt = 1, r = p, nr = a % p, q, tmp;
        while (nr != 0) begin
            q = r / nr;
            tmp = t - q * nt; t = nt; nt = tmp;
            tmp = r - q * nr; r = nr; nr = tmp;
        end
        if (t < 0) t += p;
        return t;
    endfunction

    function automatic longint mont(input longint a, input longint b, input longint p);
        return (((a * b) % p) * inv_mod(r_mod(p), p)) % p;
    endfunction

    function automatic longint pow_mod(input longint a, input longint e, input longint p);
        longint r = 1 % p;
        for (longint i = 0; i < e; i++) r = (r * a) % p;
        return r;
    endfunction

    function automatic int exp_mults(input longint e);
        int bl = 0, pc = 0;
        for (int i = 0; i < 63; i++) if ((e >> i) & 1) begin bl = i + 1; pc++; end
        return (e == 0) ? 0 : (bl - 1) + (pc - 1);
    endfunction

    // ---------------- behavioural multiplier ----------------
    int     md_st;
    int     md_cnt;
    longint md_a, md_b, md_p;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_st   <= 0;
            md_cnt  <= 0;
            mm_done <= 1'b0;
            mm_m    <= '0;
        end else begin
            case (md_st)
                0: if (mm_start && !mm_done) begin
                    md_a   <= longint'(mm_a[63:0]);
                    md_b   <= longint'(mm_b[63:0]);
                    md_p   <= longint'(mm_p[63:0]);
                    md_cnt <= int'($urandom_range(200, 20));
                    md_st  <= 1;
                end
                1: if (md_cnt <= 1) begin
                    mm_m    <= {192'd0, 64'(mont(md_a, md_b, md_p))};
                    mm_done <= 1'b1;
                    md_st   <= 2;
                end else begin
                    md_cnt <= md_cnt - 1;
                end
                default: if (!mm_start) begin
                    mm_done <= 1'b0;
                    md_st   <= 0;
                end
            endcase
        end
    end

    // ---------------- scoreboard and monitor ----------------
    typedef struct {
        longint plain;
        longint p;
        int     pulses;
        int     lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    int               pulses_seen;
    int               busy_cyc;
    logic             prev_start, prev_mdone, prev_done;
    logic [WIDTH-1:0] prev_a, prev_b, prev_p;
    longint           got;

    always @(negedge clk) begin
        if (rst) begin
            pulses_seen = 0;
            busy_cyc    = 0;
            prev_start  = 1'b0;
            prev_mdone  = 1'b0;
            prev_done   = 1'b0;
        end else begin
            if (busy) busy_cyc++;
            if (mm_start && !prev_start) begin
                pulses_seen++;
                checks++;
                if (prev_mdone) begin
                    errors++;
                    $display("FAIL mm_start_rise: rose with mm_done=1 (required mm_done=0)");
                end
            end
            if (mm_start && prev_start) begin
                checks++;
                if (mm_a != prev_a || mm_b != prev_b || mm_p != prev_p) begin
                    errors++;
                    $display("FAIL operand_stable: mm_a/mm_b/mm_p changed while mm_start=1");
                end
            end
            if (done) begin
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: done high for two cycles (required one)");
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done=1 with no run outstanding");
                end else begin
                    cur = sb.pop_front();
                    got = mont(longint'(result[63:0]), 1, cur.p);
                    if (got != cur.plain || result[WIDTH-1:64] != '0) begin
                        errors++;
                        $display("FAIL result: plain got %0d required %0d (P=%0d)", got, cur.plain, cur.p);
                    end
                    checks++;
                    if (pulses_seen != cur.pulses) begin
                        errors++;
                        $display("FAIL pulse_count: got %0d required %0d", pulses_seen, cur.pulses);
                    end
                    checks++;
                    if (busy) begin
                        errors++;
                        $display("FAIL busy_at_done: got 1 required 0");
                    end
                    if (cur.lat >= 0) begin
                        checks++;
                        if (busy_cyc != cur.lat) begin
                            errors++;
                            $display("FAIL latency: got %0d required %0d", busy_cyc, cur.lat);
                        end
                    end
                end
                pulses_seen = 0;
                busy_cyc    = 0;
            end
            prev_start = mm_start;
            prev_mdone = mm_done;
            prev_done  = done;
            prev_a     = mm_a;
            prev_b     = mm_b;
            prev_p     = mm_p;
        end
    end

    // ---------------- stimulus ----------------
    task automatic load(input longint a, input longint e, input longint p);
        longint r = r_mod(p);
        base_m = {192'd0, 64'((a * r) % p)};
        one_m  = {192'd0, 64'(r)};
        exp    = {192'd0, 64'(e)};
        P      = {192'd0, 64'(p)};
    endtask

    task automatic expect_run(input longint a, input longint e, input longint p, input bit chk_lat);
        exp_t x;
        x.plain  = pow_mod(a, e, p);
        x.p      = p;
        x.pulses = exp_mults(e);
        x.lat    = chk_lat ? EXP_W + 1 : -1;
        sb.push_back(x);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL timeout_%s: still busy after %0d cycles (queue %0d)", tag, n, sb.size());
        end
    endtask

    task automatic run_op(input longint a, input longint e, input longint p, input bit chk_lat, input string tag);
        load(a, e, p);
        expect_run(a, e, p, chk_lat);
        pulse_start();
        wait_idle(20000, tag);
    endtask

    task automatic chk1(input string name, input logic got_v, input logic req_v);
        checks++;
        if (got_v !== req_v) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got_v, req_v);
        end
    endtask

    initial begin
        int n;
        longint rp, ra, re;
        rst    = 1'b1;
        start  = 1'b0;
        base_m = '0; one_m = '0; exp = '0; P = '0;
        repeat (3) @(negedge clk);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk1("reset_mm_start", mm_start, 1'b0);
        checks++;
        if (result != '0 || mm_a != '0 || mm_b != '0 || mm_p != '0) begin
            errors++;
            $display("FAIL reset_regs: result/mm_a/mm_b/mm_p got %0h/%0h/%0h/%0h required 0",
                     result[63:0], mm_a[63:0], mm_b[63:0], mm_p[63:0]);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed cases.
        run_op(65, 0, 997, 1'b1, "exp0");
        run_op(65, 1, 997, 1'b0, "exp1");
        run_op(5, 3, 997, 1'b0, "exp3");
        run_op(65, 995, 997, 1'b0, "fermat997");

        // start held across done: exactly one extra run after returning to IDLE.
        load(13, 87, 89);
        expect_run(13, 87, 89, 1'b0);
        expect_run(13, 87, 89, 1'b0);
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (!done && n < 20000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20000) begin
            errors++;
            $display("FAIL timeout_held_first: no done after %0d cycles", n);
        end
        @(negedge clk);
        start = 1'b0;
        chk1("held_restart_busy", busy, 1'b1);
        // start pulse with different inputs while busy must be ignored.
        repeat (10) @(negedge clk);
        load(7, 5, 89);
        pulse_start();
        load(13, 87, 89);
        wait_idle(20000, "held_second");

        // Randomized runs.
        for (int k = 0; k < 6; k++) begin
            rp = longint'($urandom_range(4095, 3)) | 1;
            ra = longint'($urandom_range(32'(rp - 1), 0));
            re = longint'($urandom_range(4095, 0));
            run_op(ra, re, rp, (re == 0), "random");
        end

        // Reset in the middle of a multiply step.
        load(65, 995, 997);
        expect_run(65, 995, 997, 1'b0);
        pulse_start();
        n = 0;
        while (!(mm_start && mm_a != mm_b) && n < 20000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20000) begin
            errors++;
            $display("FAIL timeout_mul_wait: never reached a multiply step");
        end
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk1("async_rst_mm_start", mm_start, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        chk1("async_rst_done", done, 1'b0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_op(65, 995, 997, 1'b0, "after_reset");

        // No stray completions afterwards.
        repeat (300) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
- Sequencer that sits directly upstream of the 256-bit Montgomery multiplier (montgomery).
- Computes a Montgomery-domain modular exponentiation, result = base_m^exp (Montgomery form), by left-to-right square-and-multiply.
- Drives the multiplier through its start/done handshake.
- Primary use in the point-arithmetic datapath is field inversion via Fermat: exp = P-2.

Parameters:
- WIDTH, 256, operand/modulus width; must equal the multiplier width.
- EXP_W, 256, exponent width; bit counter is $clog2(EXP_W) bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request; sampled only in IDLE.
- base_m  in  WIDTH  base in Montgomery form (a*R mod P, R=2^WIDTH).
- one_m  in  WIDTH  R mod P (Montgomery one).
- exp  in  EXP_W  exponent.
- P  in  WIDTH  odd modulus.
- result  out  WIDTH  Montgomery-form result.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- mm_start  out  1  multiplier request.
- mm_a  out  WIDTH  multiplier operand A.
- mm_b  out  WIDTH  multiplier operand B.
- mm_p  out  WIDTH  multiplier modulus.
- mm_m  in  WIDTH  multiplier result.
- mm_done  in  1  multiplier completion (may be held high).

Behaviour:
- Reset (async, immediate): state=IDLE; result, mm_a, mm_b, mm_p = 0; busy, done, mm_start = 0.
- Start, IDLE & start=1:
  - Latch base_m, one_m, exp, P into internal registers; input changes are ignored afterwards.
  - busy=1; bit index i=EXP_W-1; next state SCAN.
  - start while busy is ignored.
- SCAN: one exponent bit per cycle, MSB first; leading zeros are skipped with no multiplications.
  - First set bit at i: acc=base; then i-1 -> SQR_REQ.
  - If i was 0, go straight to FIN.
  - exp==0: acc=one_m -> FIN. Latency is EXP_W+1 cycles, zero mm_start pulses.
- SQR_REQ: mm_a=mm_b=acc, mm_p=P, mm_start=1 -> SQR_WAIT.
- SQR_WAIT: mm_start held 1 and operands stable until mm_done=1.
  - On that edge: acc=mm_m, mm_start=0 -> SQR_REL.
- SQR_REL: wait for mm_done=0.
  - Then bit i=1 -> MUL_REQ.
  - Else: i==0 -> FIN, otherwise i-1 -> SQR_REQ.
- MUL_REQ / MUL_WAIT / MUL_REL: same as the SQR states with mm_a=acc, mm_b=base.
  - After release: i==0 -> FIN, otherwise i-1 -> SQR_REQ.
- FIN: result=acc, done=1 for exactly one cycle, busy=0 -> IDLE.
- result holds its value until the next FIN; it is not cleared by a new start.
- Multiplication count = (bitlen(exp)-1) + (popcount(exp)-1) for exp>0.
- Handshake rules:
  - mm_start never rises while mm_done=1.
  - mm_start falls the cycle after mm_done is seen.
  - mm_a, mm_b, mm_p never change while mm_start=1.
- mm_done high outside a WAIT state is ignored.
- Reset mid-operation: mm_start drops asynchronously; the next start begins cleanly.
  - A multiplier left mid-computation is reset by the shared system reset.
- No timeout; a hung multiplier leaves busy=1 until reset.
- All arithmetic is delegated to the multiplier; the block does no modular reduction itself.

Test Plan:
- Bench uses a behavioural Montgomery multiplier model (A*B*R^-1 mod P) with a random 20-200 cycle latency that holds done until start falls. Results are checked in plain form after conversion.
- exp=0, P=997, base=65 -> result=one_m; 0 mm_start pulses; done EXP_W+1 cycles after start.
- exp=1 -> result=base_m, 0 pulses. exp=3, base=5, P=997 -> plain result 125, 2 pulses.
- Fermat inverse: P=997, a=65, exp=995 (0b1111100011) -> plain result 951 (65*951 mod 997 = 1); exactly 15 pulses.
- Second run: P=89, a=13, exp=87 -> plain result 48 (13*48 mod 89 = 1).
  - start held high across done -> a second run starts only after return to IDLE.
  - start pulsed while busy -> ignored.
- Checker asserts:
  - mm_start never rises with mm_done=1.
  - operands stable while mm_start=1.
  - done is exactly one cycle.
- Assert rst during MUL_WAIT of the exp=995 run -> mm_start, busy, done = 0 in the same cycle. A restart with exp=995 then yields 951.
